// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
//   Shares one single-port block RAM between an instruction-fetch port
//   (read only) and a data port (read/write with byte mask). One access is
//   granted per cycle. A lone requester is granted immediately, and conflicts
//   alternate between the two ports. Read data comes straight from the memory
//   one cycle after the grant. A registered one-hot tag steers the rvalid
//   back to the port that issued the read.
//
//   Optional feature macro: BRAM_ARB_PERF_EN adds a saturating 16-bit
//   conflict counter on port conflict_cnt.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req/i_addr          fetch request and byte address
//   i_gnt                 fetch accepted this cycle
//   i_rvalid/i_rdata      fetch read response (one cycle after i_gnt)
//   d_req/d_we/d_addr/d_wdata  data request: byte mask (0 = read), addr, data
//   d_gnt                 data accepted this cycle
//   d_rvalid/d_rdata      data read response (one cycle after d_gnt, reads only)
//   mem_en/mem_we/mem_addr/mem_wdata  memory command
//   mem_rdata             memory read data, valid one cycle after mem_en
//   conflict_cnt          saturating conflict count (BRAM_ARB_PERF_EN only)
// ---------------------------------------------------------------------------
module bram_arbiter #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic [3:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef BRAM_ARB_PERF_EN
    ,
    output logic [15:0]   conflict_cnt
`endif
);

    // prio_d_q = 1: the data port wins the next conflict.
    logic prio_d_q, prio_d_d;
    // Response tag: which port owns the read data arriving next cycle.
    logic rd_i_q, rd_i_d;
    logic rd_d_q, rd_d_d;
    logic conflict;

    always_comb begin
        conflict = i_req & d_req;

        // Grants are gated by rst_n so nothing reaches the memory while
        // reset is held, even with requests asserted.
        d_gnt = rst_n & d_req & (~i_req | prio_d_q);
        i_gnt = rst_n & i_req & (~d_req | ~prio_d_q);

        // After a conflict, the loser is favoured: if fetch won, data is
        // next, and the other way round. Non-conflict cycles leave it alone.
        prio_d_d = conflict ? i_gnt : prio_d_q;

        rd_i_d = i_gnt;
        rd_d_d = d_gnt & (d_we == 4'b0000);

        // The fetch port can never write: mem_we is zero unless data wins.
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt ? d_we : 4'b0000;
        mem_addr  = d_gnt ? d_addr : i_addr;
        mem_wdata = d_gnt ? d_wdata : '0;

        // Both ports see the raw memory data; only the rvalid is steered.
        i_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
        i_rvalid = rd_i_q;
        d_rvalid = rd_d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_d_q <= 1'b1;
            rd_i_q   <= 1'b0;
            rd_d_q   <= 1'b0;
        end else begin
            prio_d_q <= prio_d_d;
            rd_i_q   <= rd_i_d;
            rd_d_q   <= rd_d_d;
        end
    end

`ifdef BRAM_ARB_PERF_EN
    logic [15:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (conflict && (conflict_q != 16'hFFFF))
            conflict_d = conflict_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_q <= 16'd0;
        else        conflict_q <= conflict_d;
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
//   Drives both requesters with hold-until-grant semantics, models a one-cycle
//   BRAM behind the arbiter, and checks grants/memory command every cycle
//   against a reference of the arbitration rules. Read responses are pushed
//   into per-port queues at grant time; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;
    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int WORDS = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic [3:0]    d_we = 4'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef BRAM_ARB_PERF_EN
    logic [15:0]   conflict_cnt;
`endif

    bram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef BRAM_ARB_PERF_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM seen by the arbiter: read-first, one cycle latency.
    logic [DW-1:0] bram [0:WORDS-1];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= bram[mem_addr[AW-1:2]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) bram[mem_addr[AW-1:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    // Reference contents, updated when the model grants a write.
    logic [DW-1:0] ref_mem [0:WORDS-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { int cyc; logic [DW-1:0] data; } rsp_t;
    rsp_t qi[$];
    rsp_t qd[$];

    typedef struct { logic gi, gd, rvi, rvd; logic [DW-1:0] rdata; } obs_t;

    // Requester state (hold until granted).
    logic          pend_i = 1'b0, pend_d = 1'b0;
    logic [AW-1:0] pi_addr = '0, pd_addr = '0;
    logic [3:0]    pd_we = '0;
    logic [DW-1:0] pd_wdata = '0;
    // Winner of the most recent conflict; "fetch" after reset so data wins next.
    logic          last_win_d = 1'b0;

    task automatic new_i(input logic [AW-1:0] a);
        pend_i = 1'b1; pi_addr = a;
    endtask

    task automatic new_d(input logic [3:0] we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        pend_d = 1'b1; pd_we = we; pd_addr = a; pd_wdata = wd;
    endtask

    // One cycle: sample responses, drive pending requests, check the
    // arbitration decision and memory command, then update the model.
    task automatic step(output obs_t o);
        logic eg_i, eg_d;
        @(negedge clk);
        o.rvi = i_rvalid; o.rvd = d_rvalid; o.rdata = i_rdata;
        i_req = pend_i; i_addr = pi_addr;
        d_req = pend_d; d_addr = pd_addr; d_we = pd_we; d_wdata = pd_wdata;
        #2;
        o.gi = i_gnt; o.gd = d_gnt;
        if (pend_i && pend_d) begin
            eg_d = !last_win_d;
            eg_i = last_win_d;
            last_win_d = eg_d;
        end else begin
            eg_d = pend_d;
            eg_i = pend_i;
        end
        chk("i_gnt", i_gnt, eg_i);
        chk("d_gnt", d_gnt, eg_d);
        chk("mem_en", mem_en, eg_i | eg_d);
        chk("mem_we", mem_we, eg_d ? pd_we : 4'b0);
        if (eg_d) begin
            chk("mem_addr_d", mem_addr, pd_addr);
            if (pd_we != 4'b0) chk("mem_wdata", mem_wdata, pd_wdata);
        end else if (eg_i) begin
            chk("mem_addr_i", mem_addr, pi_addr);
        end
        if (eg_i) begin
            qi.push_back('{cyc + 1, ref_mem[pi_addr[AW-1:2]]});
            pend_i = 1'b0;
        end
        if (eg_d) begin
            if (pd_we == 4'b0) qd.push_back('{cyc + 1, ref_mem[pd_addr[AW-1:2]]});
            else
                for (int b = 0; b < 4; b++)
                    if (pd_we[b]) ref_mem[pd_addr[AW-1:2]][8*b +: 8] = pd_wdata[8*b +: 8];
            pend_d = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        qi.delete(); qd.delete();
        pend_i = 1'b0; pend_d = 1'b0; last_win_d = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_we = 4'hF;
        repeat (2) begin
            @(negedge clk); #2;
            chk("rst_i_gnt", i_gnt, 1'b0);
            chk("rst_d_gnt", d_gnt, 1'b0);
            chk("rst_mem_en", mem_en, 1'b0);
            chk("rst_mem_we", mem_we, 4'b0);
            chk("rst_i_rvalid", i_rvalid, 1'b0);
            chk("rst_d_rvalid", d_rvalid, 1'b0);
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 4'b0;
        rst_n = 1'b1;
    endtask

    // Response monitor.
    rsp_t ri, rd;
    always @(negedge clk) begin
        if (i_rvalid) begin
            if (qi.size() == 0) chk("i_rvalid_unexpected", 1, 0);
            else begin
                ri = qi.pop_front();
                chk("i_rvalid_cycle", cyc, ri.cyc);
                chk("i_rdata", i_rdata, ri.data);
            end
        end else if (qi.size() > 0 && qi[0].cyc <= cyc) begin
            chk("i_rvalid_missing", 0, 1);
            void'(qi.pop_front());
        end
        if (d_rvalid) begin
            if (qd.size() == 0) chk("d_rvalid_unexpected", 1, 0);
            else begin
                rd = qd.pop_front();
                chk("d_rvalid_cycle", cyc, rd.cyc);
                chk("d_rdata", d_rdata, rd.data);
            end
        end else if (qd.size() > 0 && qd[0].cyc <= cyc) begin
            chk("d_rvalid_missing", 0, 1);
            void'(qd.pop_front());
        end
    end

    initial begin
        obs_t o;
        logic [3:0] pat;
        logic [AW-1:0] a;

        for (int k = 0; k < WORDS; k++) begin
            bram[k] = $urandom;
            ref_mem[k] = bram[k];
        end
        bram[16] = 32'h00000013; ref_mem[16] = 32'h00000013;
        bram[64] = 32'h11223344; ref_mem[64] = 32'h11223344;

        do_reset();

        // Both ports requesting from reset: d, i, d, i.
        pat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            if (!pend_i) new_i(AW'($urandom_range(0, 255)));
            if (!pend_d) new_d(4'b0, AW'($urandom_range(0, 255)), '0);
            step(o);
            chk("conflict_order", o.gd, pat[k]);
        end
        repeat (3) step(o);

        // Continuous data stream, fetch joins for the last two: d, d, i.
        pat = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            if (!pend_d) new_d(4'b0, AW'(4 * k), '0);
            if (k >= 1 && !pend_i) new_i(AW'(8 * k));
            step(o);
            chk("stream_order", o.gd, pat[k]);
            chk("stream_no_idle", o.gi | o.gd, 1'b1);
        end
        repeat (3) step(o);

        // Lone fetch read at 0x0040.
        new_i(AW'(14'h0040));
        step(o);
        chk("fetch_gnt", o.gi, 1'b1);
        step(o);
        chk("fetch_rvalid", o.rvi, 1'b1);
        chk("fetch_rdata", o.rdata, 32'h00000013);
        chk("fetch_no_drvalid", o.rvd, 1'b0);

        // Partial write then read back.
        new_d(4'b0011, AW'(14'h0100), 32'hDEADBEEF);
        step(o);
        new_d(4'b0000, AW'(14'h0100), '0);
        step(o);
        chk("write_no_rvalid", o.rvd, 1'b0);
        step(o);
        chk("rmw_rvalid", o.rvd, 1'b1);
        chk("rmw_rdata", o.rdata, 32'h1122BEEF);
        step(o);

        // Reset right after a granted read: response dropped, priority restored.
        new_i(AW'(14'h0040));
        step(o);
        @(posedge clk);
        #1;
        do_reset();
        new_i(AW'(14'h0010));
        new_d(4'b0, AW'(14'h0020), '0);
        step(o);
        chk("post_reset_d_wins", o.gd, 1'b1);
        repeat (3) step(o);

        // Random traffic with a mix of reads, partial writes and idle cycles.
        for (int k = 0; k < 2000; k++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) new_i(AW'($urandom_range(0, 255)));
            if (!pend_d && $urandom_range(0, 1) == 1) begin
                a = AW'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) new_d(4'b0, a, '0);
                else new_d(4'($urandom_range(1, 15)), a, $urandom);
            end
            step(o);
        end
        repeat (4) step(o);
        chk("i_queue_drained", qi.size(), 0);
        chk("d_queue_drained", qd.size(), 0);

`ifdef BRAM_ARB_PERF_EN
        do_reset();
        @(negedge clk); #2;
        chk("perf_reset", conflict_cnt, 16'd0);
        for (int k = 0; k < 5; k++) begin
            new_i(AW'(4 * k)); new_d(4'b0, AW'(4 * k + 64), '0);
            step(o);
            if (pend_i) step(o);
            if (pend_d) step(o);
        end
        step(o);
        chk("perf_count5", conflict_cnt, 16'd5);
        for (int k = 0; k < 65535; k++) begin
            if (!pend_i) new_i(AW'(4 * (k % 32)));
            if (!pend_d) new_d(4'b0, AW'(4 * (k % 32)), '0);
            step(o);
        end
        pend_i = 1'b0; pend_d = 1'b0;
        step(o);
        chk("perf_saturate", conflict_cnt, 16'hFFFF);
        repeat (2) step(o);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 14, byte-address width of the shared memory.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port i_req, input, 1, instruction-fetch read request.
REQ-006 SHALL have port i_addr, input, AW, fetch byte address.
REQ-007 SHALL have port i_gnt, output, 1, fetch request accepted this cycle.
REQ-008 SHALL have ports i_rvalid (output, 1) and i_rdata (output, DW): fetch read data and its qualifier.
REQ-009 SHALL have port d_req, input, 1, data-port request.
REQ-010 SHALL have ports d_we (input, 4), d_addr (input, AW) and d_wdata (input, DW): byte write mask, byte address and write data.
REQ-011 SHALL have port d_gnt, output, 1, data request accepted this cycle.
REQ-012 SHALL have ports d_rvalid (output, 1) and d_rdata (output, DW): data-port read data and its qualifier.
REQ-013 SHALL have ports mem_en (output, 1), mem_we (output, 4), mem_addr (output, AW) and mem_wdata (output, DW) driving the memory.
REQ-014 SHALL have port mem_rdata, input, DW, memory read data, valid one cycle after an enabled access.
REQ-015 SHALL have port conflict_cnt, output, 16, saturating conflict count (only when BRAM_ARB_PERF_EN is defined).

Function
REQ-016 SHALL grant at most one requester per cycle; grant is combinational from i_req, d_req and the priority register.
REQ-017 SHALL grant a lone requester in the same cycle, giving one access per cycle and no bubbles.
REQ-018 SHALL resolve a conflict (both requests high) round-robin; a 1-bit priority register records the winner of each conflict and favours the other port at the next conflict.
REQ-019 SHALL update the priority register only on conflict cycles.
REQ-020 SHALL drive mem_en = i_gnt | d_gnt.
REQ-021 SHALL drive mem_addr and mem_wdata from the granted port, and mem_we = d_we when d_gnt else 4'b0000.
REQ-022 SHALL never write from the fetch port.
REQ-023 SHALL pass addr[1:0] through unmodified; word alignment is the memory's concern.
REQ-024 SHALL treat a data access as a read when d_we == 0 and as a write otherwise, including partial masks.
REQ-025 SHALL register a one-hot response tag {rd_i, rd_d} on each granted read.
REQ-026 SHALL assert i_rvalid or d_rvalid exactly one cycle after the grant; writes produce no rvalid.
REQ-027 SHALL drive i_rdata = d_rdata = mem_rdata, unregistered; only rvalid is port-specific.
REQ-028 SHALL keep rvalid to each port in grant order, since latency is fixed at 1.
REQ-029 SHALL drive mem_en low with mem_we = 0 when there is no request, and leave the tag clear next cycle.
REQ-030 SHALL require requesters to hold req/addr/data until gnt; the arbiter never buffers a request.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear the tag (i_rvalid = d_rvalid = 0) and set priority so the data port wins the first conflict.
REQ-032 SHALL drop any pending response on reset mid-access, with no rvalid after release.
REQ-033 SHALL hold i_gnt, d_gnt, mem_en and mem_we at 0 while rst_n is low, regardless of requests.

Configuration
REQ-034 SHALL, when BRAM_ARB_PERF_EN is defined, include port conflict_cnt, reset to 0, incrementing on each conflict cycle and saturating at 16'hFFFF.
REQ-035 SHALL, when BRAM_ARB_PERF_EN is undefined, omit the conflict_cnt port and counter logic, with arbitration behaviour identical.

Verification
REQ-036 SHALL cover: i_req alone at i_addr 0x0040 (mem holds 0x00000013) -> i_gnt same cycle, mem_we = 0, i_rvalid = 1 with i_rdata 0x00000013 next cycle, d_rvalid = 0.
REQ-037 SHALL cover: d write d_we 4'b0011, addr 0x0100, data 0xDEADBEEF, then d read of 0x0100 over old 0x11223344 -> d_rvalid with 0x1122BEEF, no rvalid on the write cycle.
REQ-038 SHALL cover: both ports requesting for 4 cycles after reset -> grants d, i, d, i; rvalids follow one cycle later in the same order.
REQ-039 SHALL cover: continuous d_req for 3 cycles, i_req for the last 2 -> d, d, then i at the conflict (priority per REQ-018), no idle cycle.
REQ-040 SHALL cover: rst_n low in the cycle after a granted read -> no rvalid asserted, and after release the first conflict goes to the data port.
REQ-041 SHALL cover: with BRAM_ARB_PERF_EN defined, 5 conflict cycles -> conflict_cnt = 5; forced to 0xFFFF, one more conflict leaves it at 0xFFFF.
